// File: rtl/uart_rx1.sv
// 8N1 serial receiver with a 4-entry byte FIFO behind a Wishbone classic slave.
// Data register pops the FIFO on read; status register carries sticky W1C error flags.
module uart_rx1 #(
  parameter logic [31:0] ADR          = 32'h100,
  parameter int unsigned CLKS_PER_BIT = 2500,
  parameter int unsigned DEPTH        = 4
) (
  input  logic        clk_48_i,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  input  logic        rx_i,
  output logic        irq_o
);

  localparam int unsigned CW = 12;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(DEPTH);

  typedef enum logic [2:0] {
    S_ARM,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state, state_next;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shreg, shreg_next;
  logic            push, ferr_set;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   count, count_next;
  logic            ovr, ferr;
  logic            empty, full, push_ok, pop, ovr_set;
  logic            hit_data, hit_stat, req, clr_ovr, clr_ferr;
  logic [31:0]     status;
  logic [7:0]      head;
  logic            unused_bits;

  // Byte selects and the non-W1C write bits carry no meaning here.
  assign unused_bits = ^{sel_i, dat_i[31:4], dat_i[1:0]};

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_48_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_48_i) begin
    if (rst_i) begin
      state   <= S_ARM;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
    end
  end

  // Receiver next-state: half-bit to the start centre, then full bits.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    push         = 1'b0;
    ferr_set     = 1'b0;
    case (state)
      S_ARM: begin
        if (rx_s) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (!rx_s) begin
          cnt_next   = HALF_LOAD;
          state_next = S_START;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            state_next   = S_DATA;
            cnt_next     = FULL_LOAD;
            bit_idx_next = 3'd0;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          shreg_next = {rx_s, shreg[7:1]};
          cnt_next   = FULL_LOAD;
          if (bit_idx == 3'd7) state_next = S_STOP;
          else bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            push       = 1'b1;
            state_next = S_IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = S_ARM;
          end
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: state_next = S_ARM;
    endcase
  end

  assign hit_data = (adr_i == ADR);
  assign hit_stat = (adr_i == ADR + 32'd4);
  assign req      = cyc_i & stb_i & (hit_data | hit_stat) & ~ack_o;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop      = req & ~we_i & hit_data & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push & (~full | pop);
  assign ovr_set  = push & full & ~pop;
  assign clr_ovr  = req & we_i & hit_stat & dat_i[2];
  assign clr_ferr = req & we_i & hit_stat & dat_i[3];
  assign head     = mem[rd_ptr];
  assign status   = {28'd0, ferr, ovr, full, ~empty};

  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + NW'(1);
      2'b01:   count_next = count - NW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_48_i) begin
    if (!rst_i && push_ok) mem[wr_ptr] <= shreg;
  end

  // FIFO bookkeeping and sticky flags; a set beats a same-cycle clear.
  always_ff @(posedge clk_48_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      irq_o <= (count_next != '0);
      ovr   <= ovr_set | (ovr & ~clr_ovr);
      ferr  <= ferr_set | (ferr & ~clr_ferr);
    end
  end

  // Registered bus response; dat_o is zero outside the ack cycle.
  always_ff @(posedge clk_48_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= req;
      if (req && !we_i) begin
        if (hit_data) dat_o <= empty ? 32'd0 : {24'd0, head};
        else          dat_o <= status;
      end else begin
        dat_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx1.sv
// Randomized bench for uart_rx1 against a frame-level queue model of the receive FIFO.
// Uses a short bit period so many frames fit in a small cycle budget.
module tb_uart_rx1;

  localparam int unsigned C     = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] ADR   = 32'h100;
  localparam logic [31:0] STAT  = ADR + 32'd4;
  localparam int unsigned LAT   = C / 2 + 9 * C;

  logic        clk, rst, cyc, stb, we, rx, ack, irq;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;

  int n_checks, n_fail, n, lat, acks;
  logic [31:0] q, dor;
  logic [3:0]  pat;
  bit          a;
  logic [7:0]  b;

  logic [7:0] mq[$];
  bit         m_ovr, m_ferr;

  uart_rx1 #(.ADR(ADR), .CLKS_PER_BIT(C), .DEPTH(DEPTH)) dut (
    .clk_48_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .we_i(we),
    .stb_i(stb), .cyc_i(cyc), .sel_i(sel), .dat_o(rdat), .ack_o(ack),
    .rx_i(rx), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Frame-level reference model
  task automatic m_frame(input logic [7:0] d, input bit good);
    if (!good) m_ferr = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(d);
    else m_ovr = 1'b1;
  endtask

  function automatic logic [31:0] m_status();
    return {28'd0, m_ferr, m_ovr, mq.size() == DEPTH, mq.size() != 0};
  endfunction

  task automatic wait_c(input int unsigned k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic bus(input logic [31:0] ad, input logic w, input logic [31:0] d,
                     output logic [31:0] rd, output bit got_ack);
    adr = ad; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
    got_ack = 1'b0; rd = '0;
    for (int i = 0; i < 4 && !got_ack; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got_ack = 1'b1;
        rd = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] rv, ev;
    bit ok;
    bus(ADR, 1'b0, 32'd0, rv, ok);
    check({tag, "_ack"}, 32'(ok), 32'd1);
    ev = (mq.size() != 0) ? {24'd0, mq.pop_front()} : 32'd0;
    check(tag, rv, ev);
  endtask

  task automatic rd_stat(input string tag);
    logic [31:0] rv;
    bit ok;
    bus(STAT, 1'b0, 32'd0, rv, ok);
    check({tag, "_ack"}, 32'(ok), 32'd1);
    check(tag, rv, m_status());
  endtask

  task automatic wr_stat(input logic [31:0] d);
    logic [31:0] rv;
    bit ok;
    bus(STAT, 1'b1, d, rv, ok);
    check("w1c_ack", 32'(ok), 32'd1);
    if (d[2]) m_ovr = 1'b0;
    if (d[3]) m_ferr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit good, input int unsigned hold);
    @(posedge clk); #1;
    rx = 1'b0;
    wait_c(C);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_c(C);
    end
    rx = good;
    wait_c(C);
    if (!good && hold > 0) wait_c(hold);
    rx = 1'b1;
    wait_c(good ? 2 : C);
  endtask

  task automatic send_rx(input logic [7:0] d, input bit good, input int unsigned hold);
    send_frame(d, good, hold);
    m_frame(d, good);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: no finish within 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    m_ovr = 1'b0; m_ferr = 1'b0;
    rst = 1'b1; rx = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = 4'hF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_c(2);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rd_stat("rst_stat");

    // Single byte with irq latency measured from the pin edge minus sync delay
    fork
      send_frame(8'h54, 1'b1, 0);
      begin
        @(posedge clk); #1;
        n = 0;
        while (!irq && n < 12 * C) begin
          @(posedge clk); #1;
          n++;
        end
      end
    join
    m_frame(8'h54, 1'b1);
    lat = n - 2;
    check("irq_lat", (lat >= int'(LAT) - 2 && lat <= int'(LAT) + 2) ? 32'(LAT) : 32'(lat), 32'(LAT));
    rd_stat("t1_stat");
    rd_data("t1_data");
    rd_stat("t1_stat2");
    check("t1_irq", 32'(irq), 32'd0);

    // Overflow: five bytes into four slots
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1, 0);
    rd_stat("t2_stat");
    for (int i = 0; i < 4; i++) rd_data("t2_data");
    wr_stat(32'h4);
    rd_stat("t2_clr");

    // Framing error with the line held low past the stop bit
    send_rx(8'h41, 1'b0, 3 * C);
    check("t3_irq", 32'(irq), 32'd0);
    rd_stat("t3_ferr");
    send_rx(8'h41, 1'b1, 0);
    rd_stat("t3_stat2");
    rd_data("t3_data");
    wr_stat(32'h8);
    rd_stat("t3_clr");

    // Short low glitch is rejected
    rx = 1'b0;
    wait_c(C / 2 - 4);
    rx = 1'b1;
    wait_c(2 * C);
    rd_stat("t4_stat");
    check("t4_irq", 32'(irq), 32'd0);
    send_rx(8'($urandom), 1'b1, 0);
    rd_data("t4_after");

    // Reset in the middle of data bit 3 with two bytes queued
    send_rx(8'($urandom), 1'b1, 0);
    send_rx(8'($urandom), 1'b1, 0);
    b = 8'hF8 | 8'($urandom_range(0, 7));
    fork
      send_frame(b, 1'b1, 0);
      begin
        @(posedge clk); #1;
        wait_c(4 * C + C / 2);
        rst = 1'b1;
        wait_c(3);
        rst = 1'b0;
      end
    join
    mq.delete();
    m_ovr = 1'b0; m_ferr = 1'b0;
    rd_stat("t5_stat");
    check("t5_irq", 32'(irq), 32'd0);
    send_rx(8'($urandom), 1'b1, 0);
    rd_data("t5_data");
    rd_stat("t5_stat2");

    // Unmapped address never acks
    adr = ADR + 32'd8; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    acks = 0; dor = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      acks += int'(ack);
      dor |= rdat;
    end
    cyc = 1'b0; stb = 1'b0;
    check("bad_adr_ack", 32'(acks), 32'd0);
    check("bad_adr_dat", dor, 32'd0);

    // Held strobe acks every other cycle
    adr = STAT; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    check("held_ack", 32'(pat), 32'h5);

    // Data read lands on the same edge as a push into a full FIFO
    for (int i = 0; i < 4; i++) send_rx(8'($urandom), 1'b1, 0);
    b = 8'($urandom);
    fork
      send_frame(b, 1'b1, 0);
      begin
        @(posedge clk); #1;
        wait_c(LAT + 2);
        rd_data("t7_coinc");
      end
    join
    m_frame(b, 1'b1);
    rd_stat("t7_stat");
    for (int i = 0; i < 4; i++) rd_data("t7_data");
    rd_stat("t7_empty");

    // Randomized traffic, reads, status writes
    for (int it = 0; it < 12; it++) begin
      int nf, nr;
      nf = $urandom_range(1, 6);
      for (int j = 0; j < nf; j++)
        send_rx(8'($urandom), $urandom_range(0, 5) != 0, 0);
      nr = $urandom_range(0, 5);
      for (int j = 0; j < nr; j++) rd_data("rnd_data");
      rd_stat("rnd_stat");
      check("rnd_irq", 32'(irq), 32'(mq.size() != 0));
      if ($urandom_range(0, 2) == 0) wr_stat($urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus(ADR, 1'b1, $urandom, q, a);
        check("rnd_dwr_ack", 32'(a), 32'd1);
      end
    end
    wr_stat(32'hC);
    while (mq.size() != 0) rd_data("drain");
    rd_stat("final_stat");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
